ammrv_2x_bridge: RTL and testbench
==================================

Name: ammrv_2x_bridge

Overview:
Single-command Avalon-MM rate bridge. Its slave port belongs to a half-rate domain, and its master port runs at full rate. Only one clock exists (the fast clock, clk). The half-rate domain is represented by the phase-enable input clk_1x_en. The bridge sits between a slow-rate bus master (e.g. a CPU) and a fast-rate interconnect.

Parameters:
P_PASSTHROUGH, 0, 1 = pure combinational wiring s_*<->m_* (legal only with clk_1x_en tied 1); 0 = registered rate bridge
ADDR_W, 32, address width
DATA_W, 32, data width; byteenable width = DATA_W/8
RD_FIFO_DEPTH, 4, read-response buffer depth (power of 2, >=2)

Ports:
clk  in  1  single clock, fast (2x) rate
reset_n  in  1  synchronous, active-low reset
clk_1x_en  in  1  high for exactly one clk cycle in every two; marks slow-domain edges
s_address  in  ADDR_W  slave address
s_byteenable  in  DATA_W/8  slave byte enables
s_writedata  in  DATA_W  slave write data
s_read  in  1  slave read request
s_write  in  1  slave write request
s_waitrequest  out  1  slave stall; low = command accepted
s_readdata  out  DATA_W  read response data
s_readdatavalid  out  1  read response strobe, one slow cycle
m_address  out  ADDR_W  master address (registered)
m_byteenable  out  DATA_W/8  master byte enables
m_writedata  out  DATA_W  master write data
m_read  out  1  master read request
m_write  out  1  master write request
m_waitrequest  in  1  master stall
m_readdata  in  DATA_W  master read data
m_readdatavalid  in  1  master read data strobe

Behaviour:
- Slow edge = rising clk edge with clk_1x_en=1. All s_* inputs are sampled only at slow edges. All s_* outputs are registered and change only at slow edges, so they stay stable for a full slow period.
- Reset (reset_n=0 at clk edge, regardless of clk_1x_en):
  - s_waitrequest=1, s_readdatavalid=0, s_readdata=0.
  - m_read=0, m_write=0, m_address/m_byteenable/m_writedata=0.
  - FSM=IDLE, read FIFO empty, outstanding count=0.
- Command FSM states:
  - IDLE: at a slow edge with s_read|s_write=1 and outstanding<RD_FIFO_DEPTH, capture address, byteenable, writedata and rnw, then go to MREQ. If s_read and s_write are both 1, treat the command as a read.
  - MREQ: m_read or m_write held high with the captured fields. At any clk edge with m_waitrequest=0, drop m_read/m_write, increment outstanding if the command is a read, and go to ACK_WAIT.
  - ACK_WAIT: at the next slow edge, set s_waitrequest=0 and go to ACK.
  - ACK: at the next slow edge, set s_waitrequest=1 and go to IDLE. The s_read/s_write still asserted at this edge belongs to the finished command and must NOT be captured again.
- Every accepted slave command produces exactly one master command; write data and fields are forwarded bit-exact.
- Read path:
  - Any clk edge with m_readdatavalid=1 pushes m_readdata into the FIFO, regardless of phase.
  - At each slow edge, if the FIFO is non-empty: pop one entry to s_readdata, set s_readdatavalid=1, and decrement outstanding. Otherwise set s_readdatavalid=0 and hold s_readdata.
  - Order is preserved. Reads may be pipelined: a new command may be accepted before earlier read data returns.
  - The outstanding limit guarantees no overflow. A push and a pop in the same cycle are both honoured.
- m_readdatavalid with zero outstanding reads is ignored.
- P_PASSTHROUGH=1:
  - m_* = s_* combinationally; s_waitrequest = m_waitrequest; s_readdata/s_readdatavalid = m_readdata/m_readdatavalid.
  - No state is used.
- Minimum slave command latency is 2 slow cycles (request at slow edge k, accepted at edge k+2 when m_waitrequest=0 immediately).

Test Plan:
- Write 0x12345678 to addr 0x00000100, be=0xF, m_waitrequest=0 -> m_write one clk cycle with identical fields; s_waitrequest low for exactly one slow cycle; exactly one m_write.
- Read addr 0x40, m_waitrequest high for 3 clk then low, m_readdatavalid 2 clk later with data 0xDEADBEEF -> s_readdatavalid one slow cycle with s_readdata=0xDEADBEEF.
- Back-to-back read A, read B, write C with delayed responses 0x1, 0x2 -> s_readdata delivers 0x1 then 0x2 in order; write C forwarded intact; no duplicated m_read.
- s_read held high through ACK edge -> single m_read issued; next command is captured only if still requested at the following IDLE slow edge.
- reset_n low mid-MREQ -> next clk: m_read=m_write=0, s_waitrequest=1, FIFO cleared; no response emitted afterwards.
- Random 1000-command mix with random m_waitrequest and readdatavalid delays -> zero address/data/byteenable/readdata mismatches.

Source files
------------

// File: rtl/ammrv_2x_bridge.sv
// Avalon-MM rate bridge: half-rate slave port (phase-enabled by clk_1x_en) to a
// full-rate master port. One command in flight at a time; read returns may pipeline.
module ammrv_2x_bridge #(
  parameter int P_PASSTHROUGH = 0,
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int RD_FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clk_1x_en,
  input  logic [ADDR_W-1:0]   s_address,
  input  logic [DATA_W/8-1:0] s_byteenable,
  input  logic [DATA_W-1:0]   s_writedata,
  input  logic                s_read,
  input  logic                s_write,
  output logic                s_waitrequest,
  output logic [DATA_W-1:0]   s_readdata,
  output logic                s_readdatavalid,
  output logic [ADDR_W-1:0]   m_address,
  output logic [DATA_W/8-1:0] m_byteenable,
  output logic [DATA_W-1:0]   m_writedata,
  output logic                m_read,
  output logic                m_write,
  input  logic                m_waitrequest,
  input  logic [DATA_W-1:0]   m_readdata,
  input  logic                m_readdatavalid
);
  localparam int BE_W = DATA_W / 8;

  if (P_PASSTHROUGH != 0) begin : g_pass
    assign m_address       = s_address;
    assign m_byteenable    = s_byteenable;
    assign m_writedata     = s_writedata;
    assign m_read          = s_read;
    assign m_write         = s_write;
    assign s_waitrequest   = m_waitrequest;
    assign s_readdata      = m_readdata;
    assign s_readdatavalid = m_readdatavalid;
  end else begin : g_bridge
    localparam int PTR_W = $clog2(RD_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] MAX_OUT = CNT_W'(RD_FIFO_DEPTH);

    typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_MREQ     = 2'd1,
      ST_ACK_WAIT = 2'd2,
      ST_ACK      = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   m_address_q, m_address_d;
    logic [BE_W-1:0]     m_byteenable_q, m_byteenable_d;
    logic [DATA_W-1:0]   m_writedata_q, m_writedata_d;
    logic                m_read_q, m_read_d;
    logic                m_write_q, m_write_d;
    logic                rnw_q, rnw_d;
    logic                s_waitrequest_q, s_waitrequest_d;
    logic [DATA_W-1:0]   s_readdata_q;
    logic                s_readdatavalid_q;
    logic [DATA_W-1:0]   fifo_mem_q [RD_FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q, outstanding_q;
    logic                capture_s, accept_s, rd_accept_s, push_s, pop_s;

    assign capture_s   = (state_q == ST_IDLE) && clk_1x_en && (s_read || s_write)
                         && (outstanding_q < MAX_OUT);
    assign accept_s    = (state_q == ST_MREQ) && !m_waitrequest;
    assign rd_accept_s = accept_s && rnw_q;
    // Only data some issued read is still waiting for may enter the buffer.
    assign push_s      = m_readdatavalid && (count_q < outstanding_q);
    assign pop_s       = clk_1x_en && (count_q != {CNT_W{1'b0}});

    // State register and registered command/handshake outputs.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        state_q         <= ST_IDLE;
        m_address_q     <= {ADDR_W{1'b0}};
        m_byteenable_q  <= {BE_W{1'b0}};
        m_writedata_q   <= {DATA_W{1'b0}};
        m_read_q        <= 1'b0;
        m_write_q       <= 1'b0;
        rnw_q           <= 1'b0;
        s_waitrequest_q <= 1'b1;
      end else begin
        state_q         <= state_d;
        m_address_q     <= m_address_d;
        m_byteenable_q  <= m_byteenable_d;
        m_writedata_q   <= m_writedata_d;
        m_read_q        <= m_read_d;
        m_write_q       <= m_write_d;
        rnw_q           <= rnw_d;
        s_waitrequest_q <= s_waitrequest_d;
      end
    end

    // Next-state logic.
    always_comb begin
      state_d = state_q;
      case (state_q)
        ST_IDLE:     if (capture_s) state_d = ST_MREQ;     else state_d = ST_IDLE;
        ST_MREQ:     if (accept_s)  state_d = ST_ACK_WAIT; else state_d = ST_MREQ;
        ST_ACK_WAIT: if (clk_1x_en) state_d = ST_ACK;      else state_d = ST_ACK_WAIT;
        ST_ACK:      if (clk_1x_en) state_d = ST_IDLE;     else state_d = ST_ACK;
        default:     state_d = ST_IDLE;
      endcase
    end

    // Output next values; a simultaneous read+write is taken as a read.
    always_comb begin
      m_address_d     = m_address_q;
      m_byteenable_d  = m_byteenable_q;
      m_writedata_d   = m_writedata_q;
      m_read_d        = m_read_q;
      m_write_d       = m_write_q;
      rnw_d           = rnw_q;
      s_waitrequest_d = s_waitrequest_q;
      case (state_q)
        ST_IDLE: begin
          if (capture_s) begin
            m_address_d    = s_address;
            m_byteenable_d = s_byteenable;
            m_writedata_d  = s_writedata;
            m_read_d       = s_read;
            m_write_d      = !s_read;
            rnw_d          = s_read;
          end else begin
            rnw_d = rnw_q;
          end
        end
        ST_MREQ: begin
          if (accept_s) begin
            m_read_d  = 1'b0;
            m_write_d = 1'b0;
          end else begin
            m_read_d  = m_read_q;
          end
        end
        ST_ACK_WAIT: begin
          if (clk_1x_en) s_waitrequest_d = 1'b0; else s_waitrequest_d = s_waitrequest_q;
        end
        ST_ACK: begin
          if (clk_1x_en) s_waitrequest_d = 1'b1; else s_waitrequest_d = s_waitrequest_q;
        end
        default: s_waitrequest_d = 1'b1;
      endcase
    end

    // Read-response storage.
    always_ff @(posedge clk) begin
      if (push_s) fifo_mem_q[wr_ptr_q] <= m_readdata;
    end

    // Buffer pointers, outstanding-read count and slow-domain response output.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        wr_ptr_q          <= {PTR_W{1'b0}};
        rd_ptr_q          <= {PTR_W{1'b0}};
        count_q           <= {CNT_W{1'b0}};
        outstanding_q     <= {CNT_W{1'b0}};
        s_readdata_q      <= {DATA_W{1'b0}};
        s_readdatavalid_q <= 1'b0;
      end else begin
        if (push_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop_s) begin
          rd_ptr_q          <= rd_ptr_q + PTR_W'(1);
          s_readdata_q      <= fifo_mem_q[rd_ptr_q];
          s_readdatavalid_q <= 1'b1;
        end else if (clk_1x_en) begin
          s_readdatavalid_q <= 1'b0;
        end
        case ({push_s, pop_s})
          2'b10:   count_q <= count_q + CNT_W'(1);
          2'b01:   count_q <= count_q - CNT_W'(1);
          default: count_q <= count_q;
        endcase
        case ({rd_accept_s, pop_s})
          2'b10:   outstanding_q <= outstanding_q + CNT_W'(1);
          2'b01:   outstanding_q <= outstanding_q - CNT_W'(1);
          default: outstanding_q <= outstanding_q;
        endcase
      end
    end

    assign m_address       = m_address_q;
    assign m_byteenable    = m_byteenable_q;
    assign m_writedata     = m_writedata_q;
    assign m_read          = m_read_q;
    assign m_write         = m_write_q;
    assign s_waitrequest   = s_waitrequest_q;
    assign s_readdata      = s_readdata_q;
    assign s_readdatavalid = s_readdatavalid_q;
  end
endmodule

// File: tb/tb_ammrv_2x_bridge.sv
// Directed bench for ammrv_2x_bridge: slow-side command driver, behavioural
// full-rate slave with programmable stall/latency, and a slave-side response monitor.
module tb_ammrv_2x_bridge;
  logic        clk, reset_n, clk_1x_en;
  logic [31:0] s_address, s_writedata, s_readdata;
  logic [31:0] m_address, m_writedata, m_readdata;
  logic [3:0]  s_byteenable, m_byteenable;
  logic        s_read, s_write, s_waitrequest, s_readdatavalid;
  logic        m_read, m_write, m_waitrequest, m_readdatavalid;

  typedef struct packed {
    logic        rnw;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } cmd_t;

  typedef struct {
    logic [31:0] data;
    int          due;
  } resp_t;

  int n_checks = 0;
  int n_errors = 0;
  int cfg_wait = 0;
  int cfg_lat  = 2;
  int cyc      = 0;
  int wcnt     = 0;
  int last_due = 0;
  int mw_cyc   = 0;
  bit stray    = 1'b0;
  logic [31:0] rdq[$];
  cmd_t        mcmd_q[$];
  resp_t       pend_q[$];
  logic [31:0] sresp_q[$];

  ammrv_2x_bridge dut (
    .clk(clk), .reset_n(reset_n), .clk_1x_en(clk_1x_en),
    .s_address(s_address), .s_byteenable(s_byteenable), .s_writedata(s_writedata),
    .s_read(s_read), .s_write(s_write), .s_waitrequest(s_waitrequest),
    .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .m_address(m_address), .m_byteenable(m_byteenable), .m_writedata(m_writedata),
    .m_read(m_read), .m_write(m_write), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid)
  );

  // clk_1x_en flips just after each rising edge, so it is high at every other edge.
  initial begin
    clk = 1'b0;
    clk_1x_en = 1'b0;
    forever begin
      #5 clk = 1'b1;
      #1 clk_1x_en = ~clk_1x_en;
      #4 clk = 1'b0;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Full-rate slave: stalls cfg_wait edges, returns read data cfg_lat clocks after accept.
  initial begin
    resp_t r;
    cmd_t  c;
    m_waitrequest = 1'b1;
    m_readdatavalid = 1'b0;
    m_readdata = 32'd0;
    forever begin
      @(negedge clk);
      cyc++;
      if ((m_read || m_write) && reset_n) begin
        if (wcnt >= cfg_wait) begin
          m_waitrequest = 1'b0;
          c = {m_read, m_address, m_byteenable, m_writedata};
          mcmd_q.push_back(c);
          if (m_read) begin
            if (rdq.size() > 0) r.data = rdq.pop_front();
            else r.data = 32'hFFFF_FFFF;
            r.due = (cyc + cfg_lat > last_due) ? cyc + cfg_lat : last_due + 1;
            last_due = r.due;
            pend_q.push_back(r);
          end
        end else begin
          m_waitrequest = 1'b1;
          wcnt++;
        end
      end else begin
        m_waitrequest = 1'b1;
        wcnt = 0;
      end
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        m_readdatavalid = 1'b1;
        m_readdata = pend_q[0].data;
        void'(pend_q.pop_front());
      end else if (stray) begin
        m_readdatavalid = 1'b1;
        m_readdata = 32'hBAD0_BAD0;
        stray = 1'b0;
      end else begin
        m_readdatavalid = 1'b0;
      end
    end
  end

  // s_readdatavalid is sampled once per slow period, just before each slow edge.
  initial forever begin
    @(negedge clk);
    if (m_write) mw_cyc++;
    if (clk_1x_en && s_readdatavalid) sresp_q.push_back(s_readdata);
  end

  task automatic pre_slow();
    @(negedge clk);
    while (!clk_1x_en) @(negedge clk);
  endtask

  task automatic sl_cmd(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] wd,
                        input int hold, output int lat);
    pre_slow();
    s_address = a; s_byteenable = be; s_writedata = wd; s_read = rd; s_write = wr;
    lat = 0;
    do begin
      pre_slow();
      lat++;
    end while (s_waitrequest && lat < 400);
    if (s_waitrequest) check_eq("cmd_accept_timeout", {63'd0, s_waitrequest}, 64'd0);
    @(posedge clk);
    for (int i = 0; i < hold; i++) begin
      pre_slow();
      @(posedge clk);
    end
    @(negedge clk);
    s_read = 1'b0;
    s_write = 1'b0;
  endtask

  task automatic wait_resp(input int n, input string tag);
    for (int i = 0; i < 3000 && sresp_q.size() < n; i++) @(negedge clk);
    check_eq(tag, 64'(sresp_q.size()), 64'(n));
  endtask

  initial begin
    int   lat;
    int   lat_a[5];
    int   bad;
    cmd_t c;
    cmd_t exp_q[$];
    logic [31:0] exp_r[$];

    reset_n = 1'b0;
    s_address = 32'd0; s_byteenable = 4'd0; s_writedata = 32'd0;
    s_read = 1'b0; s_write = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_eq("rst_s_waitrequest", {63'd0, s_waitrequest}, 64'd1);
    check_eq("rst_s_readdatavalid", {63'd0, s_readdatavalid}, 64'd0);
    check_eq("rst_s_readdata", {32'd0, s_readdata}, 64'd0);
    check_eq("rst_m_rw", {62'd0, m_read, m_write}, 64'd0);
    check_eq("rst_m_addr_be", {28'd0, m_address, m_byteenable}, 64'd0);
    check_eq("rst_m_wdata", {32'd0, m_writedata}, 64'd0);
    reset_n = 1'b1;

    // Single write, no master stall.
    cfg_wait = 0; mw_cyc = 0; mcmd_q.delete();
    sl_cmd(1'b0, 1'b1, 32'h0000_0100, 4'hF, 32'h1234_5678, 0, lat);
    check_eq("wr_min_latency", 64'(lat), 64'd2);
    pre_slow();
    check_eq("wr_ack_one_slow_cycle", {63'd0, s_waitrequest}, 64'd1);
    repeat (4) pre_slow();
    check_eq("wr_cmd_count", 64'(mcmd_q.size()), 64'd1);
    c = (mcmd_q.size() > 0) ? mcmd_q[0] : '0;
    check_eq("wr_fields", {c.rnw, c.addr, c.be}, {1'b0, 32'h0000_0100, 4'hF});
    check_eq("wr_data", {32'd0, c.wd}, {32'd0, 32'h1234_5678});
    check_eq("wr_m_write_cycles", 64'(mw_cyc), 64'd1);

    // Read with a 3-edge master stall.
    cfg_wait = 3; cfg_lat = 2; mcmd_q.delete(); sresp_q.delete();
    rdq.push_back(32'hDEAD_BEEF);
    sl_cmd(1'b1, 1'b0, 32'h0000_0040, 4'hF, 32'h0, 0, lat);
    wait_resp(1, "rd_resp_arrived");
    repeat (8) pre_slow();
    check_eq("rd_resp_single", 64'(sresp_q.size()), 64'd1);
    check_eq("rd_resp_data", {32'd0, (sresp_q.size() > 0) ? sresp_q[0] : 32'd0}, {32'd0, 32'hDEAD_BEEF});
    c = (mcmd_q.size() > 0) ? mcmd_q[0] : '0;
    check_eq("rd_fields", {c.rnw, c.addr, c.be}, {1'b1, 32'h0000_0040, 4'hF});

    // Back-to-back read A, read B (read+write both high), write C; slow responses.
    cfg_wait = 0; cfg_lat = 20; mcmd_q.delete(); sresp_q.delete();
    rdq.push_back(32'h0000_0001); rdq.push_back(32'h0000_0002);
    sl_cmd(1'b1, 1'b0, 32'h0000_0200, 4'hF, 32'h0, 0, lat);
    sl_cmd(1'b1, 1'b1, 32'h0000_0204, 4'hC, 32'h0, 0, lat);
    check_eq("b2b_pipelined", 64'(sresp_q.size()), 64'd0);
    sl_cmd(1'b0, 1'b1, 32'h0000_0208, 4'h3, 32'hCAFE_F00D, 0, lat);
    wait_resp(2, "b2b_resp_count");
    check_eq("b2b_order", {(sresp_q.size() > 1) ? sresp_q[0] : 32'd0, (sresp_q.size() > 1) ? sresp_q[1] : 32'd0},
             {32'h0000_0001, 32'h0000_0002});
    repeat (4) pre_slow();
    check_eq("b2b_cmd_count", 64'(mcmd_q.size()), 64'd3);
    c = (mcmd_q.size() > 1) ? mcmd_q[1] : '0;
    check_eq("b2b_both_is_read", {c.rnw, c.addr, c.be}, {1'b1, 32'h0000_0204, 4'hC});
    c = (mcmd_q.size() > 2) ? mcmd_q[2] : '0;
    check_eq("b2b_write_fields", {c.rnw, c.addr, c.be}, {1'b0, 32'h0000_0208, 4'h3});
    check_eq("b2b_write_data", {32'd0, c.wd}, {32'd0, 32'hCAFE_F00D});

    // Request still high on the ACK edge must not be re-captured; held to the next IDLE edge it is.
    cfg_lat = 2; mcmd_q.delete(); sresp_q.delete();
    rdq.push_back(32'h0000_0011); rdq.push_back(32'h0000_0022); rdq.push_back(32'h0000_0033);
    sl_cmd(1'b1, 1'b0, 32'h0000_0300, 4'hF, 32'h0, 0, lat);
    repeat (6) pre_slow();
    check_eq("hold_ack_no_dup", 64'(mcmd_q.size()), 64'd1);
    sl_cmd(1'b1, 1'b0, 32'h0000_0304, 4'hF, 32'h0, 1, lat);
    repeat (8) pre_slow();
    check_eq("hold_idle_recapture", 64'(mcmd_q.size()), 64'd3);
    wait_resp(3, "hold_resp_count");

    // Stray m_readdatavalid with nothing outstanding.
    sresp_q.delete(); mcmd_q.delete();
    stray = 1'b1;
    repeat (6) pre_slow();
    check_eq("stray_ignored", 64'(sresp_q.size()), 64'd0);
    rdq.push_back(32'h55AA_55AA);
    sl_cmd(1'b1, 1'b0, 32'h0000_0310, 4'hF, 32'h0, 0, lat);
    wait_resp(1, "stray_next_count");
    check_eq("stray_next_data", {32'd0, (sresp_q.size() > 0) ? sresp_q[0] : 32'd0}, {32'd0, 32'h55AA_55AA});

    // Outstanding limit: the fifth read stalls until the first response drains.
    cfg_lat = 80; sresp_q.delete(); mcmd_q.delete();
    for (int i = 0; i < 5; i++) rdq.push_back(32'h0000_00A0 + 32'(i));
    for (int i = 0; i < 5; i++) sl_cmd(1'b1, 1'b0, 32'h0000_0400 + 32'(4 * i), 4'hF, 32'h0, 0, lat_a[i]);
    check_eq("limit_first_latency", 64'(lat_a[0]), 64'd2);
    check_eq("limit_fifth_stalled", {63'd0, lat_a[4] > 10}, 64'd1);
    wait_resp(5, "limit_resp_count");
    bad = 0;
    for (int i = 0; i < 5; i++)
      if (i < sresp_q.size() && sresp_q[i] !== 32'h0000_00A0 + 32'(i)) bad++;
    check_eq("limit_resp_order", 64'(bad), 64'd0);

    // Reset while a read is stuck in MREQ and another read's data is still in flight.
    cfg_wait = 0; cfg_lat = 40; sresp_q.delete();
    rdq.push_back(32'h0BAD_0001);
    sl_cmd(1'b1, 1'b0, 32'h0000_0500, 4'hF, 32'h0, 0, lat);
    cfg_wait = 1000;
    pre_slow();
    s_address = 32'h0000_0504; s_read = 1'b1;
    pre_slow();
    check_eq("rst_mid_in_mreq", {63'd0, m_read}, 64'd1);
    reset_n = 1'b0;
    s_read = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rst_mid_m_rw", {62'd0, m_read, m_write}, 64'd0);
    check_eq("rst_mid_s_wait", {63'd0, s_waitrequest}, 64'd1);
    @(negedge clk);
    reset_n = 1'b1;
    cfg_wait = 0;
    repeat (40) pre_slow();
    check_eq("rst_mid_no_resp", 64'(sresp_q.size()), 64'd0);
    rdq.delete();
    rdq.push_back(32'h600D_600D); cfg_lat = 3;
    sl_cmd(1'b1, 1'b0, 32'h0000_0508, 4'hF, 32'h0, 0, lat);
    wait_resp(1, "rst_recover_count");
    check_eq("rst_recover_data", {32'd0, (sresp_q.size() > 0) ? sresp_q[0] : 32'd0}, {32'd0, 32'h600D_600D});

    // Random mix.
    mcmd_q.delete(); sresp_q.delete(); rdq.delete();
    for (int i = 0; i < 1000; i++) begin
      logic        rd, wr;
      logic [31:0] a, wd, d;
      logic [3:0]  be;
      int          k;
      k  = $urandom_range(0, 2);
      rd = (k != 1);
      wr = (k != 0);
      a  = $urandom; wd = $urandom; d = $urandom; be = 4'($urandom);
      cfg_wait = $urandom_range(0, 3);
      cfg_lat  = $urandom_range(1, 12);
      c = {rd, a, be, wd};
      exp_q.push_back(c);
      if (rd) begin
        rdq.push_back(d);
        exp_r.push_back(d);
      end
      sl_cmd(rd, wr, a, be, wd, 0, lat);
    end
    wait_resp(exp_r.size(), "rnd_resp_count");
    repeat (4) pre_slow();
    check_eq("rnd_cmd_count", 64'(mcmd_q.size()), 64'(exp_q.size()));
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= mcmd_q.size()) bad++;
      else if ({mcmd_q[i].rnw, mcmd_q[i].addr, mcmd_q[i].be} !== {exp_q[i].rnw, exp_q[i].addr, exp_q[i].be}) bad++;
      else if (!exp_q[i].rnw && mcmd_q[i].wd !== exp_q[i].wd) bad++;
    end
    check_eq("rnd_cmd_mismatches", 64'(bad), 64'd0);
    bad = 0;
    for (int i = 0; i < exp_r.size(); i++)
      if (i >= sresp_q.size() || sresp_q[i] !== exp_r[i]) bad++;
    check_eq("rnd_resp_mismatches", 64'(bad), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
